// File: rtl/counter_cmd_pkg.sv
// Shared constants and button identifiers for the counter command front end.
package counter_cmd_pkg;

    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 500000;
    localparam int LOAD_DEFAULT_C  = 4;
    localparam int NUM_BTNS        = 3;

    typedef enum logic [1:0] {
        BTN_LOAD = 2'd0,
        BTN_DEC  = 2'd1,
        BTN_EN   = 2'd2
    } btn_id_t;

endpackage

// File: rtl/btn_debouncer.sv
// One pushbutton channel: 2-flop synchroniser, stability counter and
// registered rising-edge detect of the debounced level.
module btn_debouncer #(
    parameter int DB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press,
    output logic press_next
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any disagreement that does not persist for DB_CYCLES cycles restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Exposed so the parent can act on the same edge that raises press.
    assign press_next = stable_q & ~stable_dly_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_next;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/counter_cmd_conditioner.sv
// Conditions three bouncy buttons into load/dec/enable controls and holds
// the load reference captured from the switch bank.
module counter_cmd_conditioner
    import counter_cmd_pkg::*;
#(
    parameter int   N            = 32,
    parameter int   DB_CYCLES    = DB_CYCLES_BOARD,
    parameter int   LOAD_DEFAULT = LOAD_DEFAULT_C,
    parameter logic EN_RESET     = 1'b1,
    parameter logic DEC_RESET    = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         btn_load_raw,
    input  logic         btn_dec_raw,
    input  logic         btn_en_raw,
    input  logic [N-1:0] sw_ref,
    output logic         load,
    output logic         dec,
    output logic         enable,
    output logic [N-1:0] Load_Ref_value
);

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] stable_vec;
    logic [NUM_BTNS-1:0] press_vec;
    logic [NUM_BTNS-1:0] set_vec;
    logic                unused_stable;

    logic         dec_q;
    logic         enable_q;
    logic [N-1:0] ref_q;

    assign raw_vec = {btn_en_raw, btn_dec_raw, btn_load_raw};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debouncer #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .clock      (clock),
                .reset      (reset),
                .raw        (raw_vec[gi]),
                .stable     (stable_vec[gi]),
                .press      (press_vec[gi]),
                .press_next (set_vec[gi])
            );
        end
    endgenerate

    // Debounced levels are not needed here; only their edges drive the counter.
    assign unused_stable = ^stable_vec;

    // Actions fire on the edge that raises press, so the counter sees the
    // new reference in the same cycle as its load pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_q    <= DEC_RESET;
            enable_q <= EN_RESET;
            ref_q    <= N'(LOAD_DEFAULT);
        end else begin
            if (set_vec[BTN_LOAD]) ref_q    <= sw_ref;
            if (set_vec[BTN_DEC])  dec_q    <= ~dec_q;
            if (set_vec[BTN_EN])   enable_q <= ~enable_q;
        end
    end

    assign load           = press_vec[BTN_LOAD];
    assign dec            = dec_q;
    assign enable         = enable_q;
    assign Load_Ref_value = ref_q;

endmodule

// File: tb/tb_counter_cmd_conditioner.sv
// Scoreboard bench: stimulus queues expected output events, a monitor checks
// every cycle where load pulses or dec/enable change.
module tb_counter_cmd_conditioner;
    import counter_cmd_pkg::*;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         btn_load_raw = 1'b0;
    logic         btn_dec_raw  = 1'b0;
    logic         btn_en_raw   = 1'b0;
    logic [N-1:0] sw_ref = '0;
    logic         load;
    logic         dec;
    logic         enable;
    logic [N-1:0] Load_Ref_value;

    typedef struct {
        int           cyc;
        logic         ld;
        logic         dc;
        logic         en;
        logic [N-1:0] rv;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;

    logic         dec_exp = 1'b0;
    logic         en_exp  = 1'b1;
    logic [N-1:0] ref_exp = 32'd4;

    counter_cmd_conditioner #(
        .N            (N),
        .DB_CYCLES    (DB_CYCLES_SIM),
        .LOAD_DEFAULT (LOAD_DEFAULT_C),
        .EN_RESET     (1'b1),
        .DEC_RESET    (1'b0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_load_raw   (btn_load_raw),
        .btn_dec_raw    (btn_dec_raw),
        .btn_en_raw     (btn_en_raw),
        .sw_ref         (sw_ref),
        .load           (load),
        .dec            (dec),
        .enable         (enable),
        .Load_Ref_value (Load_Ref_value)
    );

    initial forever #10 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_btn(input btn_id_t b, input logic v);
        case (b)
            BTN_LOAD: btn_load_raw = v;
            BTN_DEC:  btn_dec_raw  = v;
            default:  btn_en_raw   = v;
        endcase
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_event(input logic ld);
        ev_t e;
        e.cyc = cyc + 7;
        e.ld  = ld;
        e.dc  = dec_exp;
        e.en  = en_exp;
        e.rv  = ref_exp;
        exp_q.push_back(e);
    endtask

    // Monitor: an output event is a load pulse or a change of dec/enable.
    initial begin
        logic prev_dec;
        logic prev_en;
        ev_t  e;
        prev_dec = 1'b0;
        prev_en  = 1'b1;
        forever begin
            @(negedge clock);
            if (reset && (load || dec !== prev_dec || enable !== prev_en)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: got load=%b dec=%b en=%b ref=%0h expected none (cycle %0d)",
                             load, dec, enable, Load_Ref_value, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", N'(cyc), N'(e.cyc));
                    check("event_load", N'(load), N'(e.ld));
                    check("event_dec", N'(dec), N'(e.dc));
                    check("event_enable", N'(enable), N'(e.en));
                    check("event_ref", Load_Ref_value, e.rv);
                end
            end
            prev_dec = dec;
            prev_en  = enable;
        end
    end

    initial begin
        // 1: reset values
        step(2);
        check("rst_load", N'(load), N'(1'b0));
        check("rst_dec", N'(dec), N'(1'b0));
        check("rst_enable", N'(enable), N'(1'b1));
        check("rst_ref", Load_Ref_value, 32'd4);
        #2 reset = 1'b1;
        step(3);

        // 2: clean load press, held, then released
        sw_ref = 32'd9;
        set_btn(BTN_LOAD, 1'b1);
        ref_exp = 32'd9;
        expect_event(1'b1);
        step(20);
        set_btn(BTN_LOAD, 1'b0);
        step(12);
        check("load_ref_held", Load_Ref_value, 32'd9);

        // 3: bouncing dec button, then steady
        for (int i = 0; i < 4; i++) begin
            set_btn(BTN_DEC, (i % 2 == 0) ? 1'b1 : 1'b0);
            step(2);
        end
        set_btn(BTN_DEC, 1'b1);
        dec_exp = 1'b1;
        expect_event(1'b0);
        step(14);
        set_btn(BTN_DEC, 1'b0);
        step(12);

        // 4: two enable presses, switches change in between
        set_btn(BTN_EN, 1'b1);
        en_exp = 1'b0;
        expect_event(1'b0);
        step(10);
        sw_ref = 32'h55;
        set_btn(BTN_EN, 1'b0);
        step(12);
        set_btn(BTN_EN, 1'b1);
        en_exp = 1'b1;
        expect_event(1'b0);
        step(10);
        set_btn(BTN_EN, 1'b0);
        step(12);
        check("ref_ignores_sw", Load_Ref_value, 32'd9);

        // 5: simultaneous load and enable
        sw_ref = 32'hA5;
        set_btn(BTN_LOAD, 1'b1);
        set_btn(BTN_EN, 1'b1);
        ref_exp = 32'hA5;
        en_exp  = 1'b0;
        expect_event(1'b1);
        step(10);
        set_btn(BTN_LOAD, 1'b0);
        set_btn(BTN_EN, 1'b0);
        step(12);

        // 6: asynchronous reset in the middle of a load debounce
        sw_ref = 32'h1234;
        set_btn(BTN_LOAD, 1'b1);
        repeat (3) @(posedge clock);
        #5 reset = 1'b0;
        #1;
        check("async_rst_load", N'(load), N'(1'b0));
        check("async_rst_dec", N'(dec), N'(1'b0));
        check("async_rst_enable", N'(enable), N'(1'b1));
        check("async_rst_ref", Load_Ref_value, 32'd4);
        dec_exp = 1'b0;
        en_exp  = 1'b1;
        @(negedge clock);
        #2 reset = 1'b1;
        ref_exp = 32'h1234;
        expect_event(1'b1);
        step(12);
        set_btn(BTN_LOAD, 1'b0);
        step(12);

        check("events_outstanding", N'(exp_q.size()), N'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
